// File: rtl/sc_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sc_fifo_param #(
    parameter int DATA_WIDTH = 25,
    parameter int ADDR_WIDTH = 7,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   cnt,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_CNT);
    assign almost_full  = (cnt >= af_thresh);
    assign almost_empty = (cnt <= ae_thresh);

    // A full FIFO still takes a write when the same-cycle read frees a slot.
    assign rd_ok = read & ~empty;
    assign wr_ok = write & (~full | rd_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (write && !wr_ok) overflow  <= 1'b1;
            if (read && empty)   underflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT == 0) begin : g_std
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_out <= '0;
                    valid    <= 1'b0;
                end else if (clear) begin
                    valid    <= 1'b0;
                end else begin
                    valid <= rd_ok;
                    if (rd_ok) data_out <= mem[rd_ptr];
                end
            end
        end else begin : g_fwft
            // Head word is presented straight from storage, so no bubble follows a pop.
            assign valid    = ~empty;
            assign data_out = empty ? '0 : mem[rd_ptr];
        end
    endgenerate

endmodule

// File: tb/tb_sc_fifo_param.sv
// Self-checking bench: standard and FWFT instances share stimulus and are
// compared against a queue-based reference model.
module tb_sc_fifo_param;

    localparam int DW    = 25;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          write;
    logic          read;
    logic [DW-1:0] data_in;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;

    logic [DW-1:0] s_data_out, f_data_out;
    logic          s_valid, f_valid;
    logic [AW:0]   s_cnt, f_cnt;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic          m_std_valid;
    logic [DW-1:0] m_std_dout;

    always #5 clk = ~clk;

    sc_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .clear(clear), .write(write), .data_in(data_in),
        .read(read), .data_out(s_data_out), .valid(s_valid),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .cnt(s_cnt),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sc_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .write(write), .data_in(data_in),
        .read(read), .data_out(f_data_out), .valid(f_valid),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .cnt(f_cnt),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        m_std_valid = 1'b0;
        m_std_dout  = '0;
    endtask

    task automatic check_output();
        int n;
        n = model_q.size();
        check("cnt",          32'(s_cnt),      32'(n));
        check("fwft_cnt",     32'(f_cnt),      32'(n));
        check("empty",        32'(s_empty),    32'(n == 0));
        check("full",         32'(s_full),     32'(n == DEPTH));
        check("fwft_full",    32'(f_full),     32'(n == DEPTH));
        check("almost_full",  32'(s_af),       32'(n >= int'(af_thresh)));
        check("almost_empty", 32'(s_ae),       32'(n <= int'(ae_thresh)));
        check("overflow",     32'(s_ovf),      32'(m_ovf));
        check("underflow",    32'(s_unf),      32'(m_unf));
        check("fwft_ovf",     32'(f_ovf),      32'(m_ovf));
        check("fwft_unf",     32'(f_unf),      32'(m_unf));
        check("std_valid",    32'(s_valid),    32'(m_std_valid));
        check("std_dout",     32'(s_data_out), 32'(m_std_dout));
        check("fwft_valid",   32'(f_valid),    32'(n != 0));
        if (n != 0) check("fwft_dout", 32'(f_data_out), 32'(model_q[0]));
    endtask

    // Drive one cycle, advance the model by the FIFO rules, then check away from the edge.
    task automatic apply_stimulus(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit was_empty, was_full, rd_ok, wr_ok;
        write   = w;
        read    = r;
        clear   = c;
        data_in = d;
        @(posedge clk);
        if (c) begin
            model_q.delete();
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            m_std_valid = 1'b0;
        end else begin
            was_empty = (model_q.size() == 0);
            was_full  = (model_q.size() == DEPTH);
            rd_ok     = r && !was_empty;
            wr_ok     = w && (!was_full || rd_ok);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            m_std_valid = rd_ok;
            if (rd_ok) m_std_dout = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
        end
        #1;
        check_output();
    endtask

    initial begin
        int pulses;
        int wp, rp;
        reset     = 1'b1;
        clear     = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        data_in   = '0;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        model_reset();
        #2;
        check_output();
        check("reset_fwft_dout", 32'(f_data_out), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill and drain, standard mode
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h100 + i));
        check("t1_full", 32'(s_full), 32'h1);
        check("t1_cnt", 32'(s_cnt), 32'h8);
        check("t1_af", 32'(s_af), 32'h1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, '0);
            if (s_valid === 1'b1) pulses++;
            check("t1_dout", 32'(s_data_out), 32'h100 + 32'(i));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        if (s_valid === 1'b1) pulses++;
        check("t1_pulses", 32'(pulses), 32'd8);
        check("t1_empty", 32'(s_empty), 32'h1);

        // Overflow then underflow, cleared by a clear pulse
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h200 + i));
        apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h1FF));
        check("t2_ovf", 32'(s_ovf), 32'h1);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        check("t2_unf", 32'(s_unf), 32'h1);
        apply_stimulus(1'b0, 1'b0, 1'b1, '0);
        check("t2_clr_ovf", 32'(s_ovf), 32'h0);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h300 + i));
        apply_stimulus(1'b1, 1'b1, 1'b0, DW'(32'h3AA));
        check("t3_full_cnt", 32'(s_cnt), 32'h8);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        check("t3_last", 32'(s_data_out), 32'h3AA);
        apply_stimulus(1'b1, 1'b1, 1'b0, DW'(32'h3BB));
        check("t3_empty_cnt", 32'(s_cnt), 32'h1);
        check("t3_empty_unf", 32'(s_unf), 32'h1);
        apply_stimulus(1'b0, 1'b1, 1'b1, '0);

        // Wrap-around stream at constant occupancy of 3
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h400 + i));
        for (int i = 3; i < 20; i++) apply_stimulus(1'b1, 1'b1, 1'b0, DW'(32'h400 + i));
        check("t4_cnt", 32'(s_cnt), 32'h3);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        check("t4_last", 32'(s_data_out), 32'h413);

        // FWFT presentation and back-to-back streaming
        apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'hABC));
        check("t5_valid", 32'(f_valid), 32'h1);
        check("t5_dout", 32'(f_data_out), 32'hABC);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b1, 1'b0, DW'(32'h500 + i));
        check("t5_stream", 32'(f_data_out), 32'h509);

        // Threshold boundaries
        af_thresh = 4'd0;
        ae_thresh = 4'd8;
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        af_thresh = 4'd6;
        ae_thresh = 4'd2;

        // Clear with write at cnt=5, then asynchronous reset mid-stream
        apply_stimulus(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h600 + i));
        apply_stimulus(1'b1, 1'b0, 1'b1, DW'(32'h6FF));
        check("t6_clr_cnt", 32'(s_cnt), 32'h0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, DW'(32'h700 + i));
        apply_stimulus(1'b1, 1'b1, 1'b0, DW'(32'h704));
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_output();
        check("t6_fwft_dout", 32'(f_data_out), 32'h0);
        #2;
        reset = 1'b0;

        // Randomised traffic with drifting bias, thresholds and rare clears
        for (int i = 0; i < 400; i++) begin
            wp = (i < 200) ? 70 : 40;
            rp = (i < 200) ? 40 : 70;
            if (i % 50 == 0) begin
                af_thresh = AW'(0) + 4'($urandom_range(0, 8));
                ae_thresh = 4'($urandom_range(0, 8));
            end
            apply_stimulus($urandom_range(0, 99) < 32'(wp),
                           $urandom_range(0, 99) < 32'(rp),
                           $urandom_range(0, 99) < 2,
                           DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_fifo_param.md
# sc_fifo_param

Parametrised single-clock FIFO that supersedes the fixed 128-deep JPEG-encoder buffers. It is generic in data width and power-of-two depth, and offers a standard registered-read mode or a first-word-fall-through (FWFT) mode. It adds runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and occupancy that saturates correctly at full. It sits between the encoder pipeline stages (e.g. Huffman output to byte packer) and toward the host/ESP32 output path.

## Interface
- DATA_WIDTH, 25, word width in bits (≥1)
- ADDR_WIDTH, 7, log2 of depth; DEPTH = 2**ADDR_WIDTH (≥1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush, highest priority
- write  in  1  write request
- data_in  in  DATA_WIDTH  write data
- read  in  1  read request (FWFT: acknowledge of current head)
- data_out  out  DATA_WIDTH  read data
- valid  out  1  standard: data_out updated this cycle; FWFT: data_out holds head word
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold
- cnt  out  ADDR_WIDTH+1  stored word count, 0..DEPTH
- full / empty  out  1  cnt==DEPTH / cnt==0
- almost_full / almost_empty  out  1  cnt>=af_thresh / cnt<=ae_thresh
- overflow / underflow  out  1  sticky error flags

## Operation
- Read accept (rd_ok) = read & ~empty. Write accept (wr_ok) = write & (~full | rd_ok).
  - Write into a full FIFO is accepted only when the same-cycle read is also accepted.
  - Read and write on an empty FIFO: read rejected, write accepted.
- cnt update: +1 if wr_ok only; −1 if rd_ok only; unchanged if both or neither.
  - cnt never exceeds DEPTH and never goes below 0.
- Pointers are ADDR_WIDTH bits. The write pointer advances on wr_ok and the read pointer on rd_ok; both wrap modulo DEPTH.
- Memory write: mem[wr_ptr] <= data_in on wr_ok only.
- overflow sets on write & ~wr_ok. underflow sets on read & empty. Both hold until reset or clear.
- clear (synchronous) forces pointers, cnt, overflow, underflow and valid to 0.
  - write and read in the clear cycle are ignored and do not set error flags.
  - Standard mode: data_out keeps its last value.
- Standard mode (FWFT=0):
  - On rd_ok, data_out <= mem[rd_ptr] and valid is 1 on the next cycle; otherwise valid is 0 and data_out holds.
- FWFT mode (FWFT=1):
  - valid = (cnt != 0). While valid, data_out equals the oldest stored word.
  - rd_ok pops it, and the next word (if any) is on data_out the following cycle.
  - cnt includes the presented word. Memory may be wrapped with an output register plus bypass so that no bubble appears.
- Flags are combinational from registered cnt and the live thresholds.
  - af_thresh = 0 makes almost_full constantly 1.
  - ae_thresh ≥ DEPTH makes almost_empty constantly 1.
- Memory contents are not reset.

## Timing
- Reset values: cnt 0, pointers 0, data_out 0, valid 0, overflow 0, underflow 0, empty 1, full 0, almost_empty 1, almost_full = (af_thresh==0).
- Reset asserted mid-operation returns everything to the reset values immediately; in-flight reads are lost.
- Standard read latency: 1 cycle (read at edge N, data_out/valid at edge N+1).
- FWFT latency: write into an empty FIFO at edge N gives valid/data_out at edge N+1.
- A read accepted at edge N shows the next head from edge N+1.
- cnt, empty and full change on the edge of the accepted access.
- Sustained throughput is 1 write + 1 read per cycle, including at full and at empty (write-only at empty).

## Test plan
Bench configuration: DATA_WIDTH=25, ADDR_WIDTH=3 (DEPTH 8).
1. **Fill and drain, standard mode.** Write 0x100..0x107 on 8 consecutive cycles. Then expect full=1, cnt=8, almost_full=1 with af_thresh=6. Read 8 cycles; data_out = 0x100..0x107, each 1 cycle after its read, valid pulses 8 times, and empty=1 at the end.
2. **Overflow and underflow.** At full, write 0x1FF with read=0: cnt stays 8, overflow=1, and 0x1FF is never read back. Drain, then read while empty: underflow=1 and cnt stays 0. Pulse clear: both flags drop to 0.
3. **Simultaneous read/write at boundaries.** At full, write and read together: cnt stays 8, the new word is accepted, and ordering is preserved. At empty, write and read together: cnt becomes 1, underflow=1.
4. **Wrap-around.** Stream 20 words with interleaved read/write, keeping cnt at 3. Output order is identical to input across 2+ pointer wraps.
5. **FWFT mode.** Write 0xABC into an empty FIFO: the next cycle shows valid=1 and data_out=0xABC with no read. Read and write back-to-back for 10 cycles: no bubble, in-order data.
6. **Clear and reset mid-stream.** With cnt=5, assert clear together with write: cnt=0, the write is ignored, empty=1. Assert reset asynchronously between edges: outputs take the reset values before the next edge.
